uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_COUNT, default 434, SHALL be the clock cycles per bit (i_clk frequency / baud); the legal range is 4..8191.
REQ-002 i_clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 i_rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 i_rx  input  1  SHALL be the asynchronous serial line (idle high, 8N1, LSB first).
REQ-005 o_data  output  8  SHALL be the last correctly framed byte, held until the next good byte.
REQ-006 o_valid  output  1  SHALL be a one-cycle pulse marking a new byte on o_data.
REQ-007 o_frame_err  output  1  SHALL be a one-cycle pulse marking a stop bit sampled low.
REQ-008 o_busy  output  1  SHALL be high whenever the state is not IDLE.

Function
REQ-009 i_rx SHALL pass through a 2-flop synchronizer; only the synchronized signal (rx_s) is used; synchronizer flops reset to 1.
REQ-010 States SHALL be IDLE, START_BIT, DATA_BIT, STOP_BIT, WAIT_HIGH; any unused encoding SHALL return to IDLE next cycle.
REQ-011 Bit counter SHALL be 13 bits; bit index SHALL be 3 bits.
REQ-012 IDLE: counter=0, index=0; when rx_s==0, go to START_BIT on the next edge.
REQ-013 START_BIT: count 0..CLK_COUNT/2-1 (integer division); at terminal count, sample rx_s: 0 -> DATA_BIT with counter=0; 1 -> IDLE (glitch rejected, no output pulse).
REQ-014 DATA_BIT: count 0..CLK_COUNT-1; at terminal count, store rx_s into shift bit[index] (LSB first) and clear counter; index 7 -> STOP_BIT, else index+1.
REQ-015 STOP_BIT: count 0..CLK_COUNT-1; at terminal count, sample rx_s: 1 -> load o_data from shift register, pulse o_valid, go to IDLE; 0 -> pulse o_frame_err, leave o_data unchanged, go to WAIT_HIGH.
REQ-016 WAIT_HIGH: remain until rx_s==1, then go to IDLE; a held-low line (break) SHALL produce exactly one o_frame_err and no further activity.
REQ-017 o_valid and o_frame_err SHALL be registered, mutually exclusive, and never high for two consecutive cycles.
REQ-018 o_valid SHALL rise 2 + 1 + CLK_COUNT/2 + 9*CLK_COUNT cycles (+/-1) after the i_rx falling edge of the start bit.
REQ-019 A start edge arriving in the same cycle as the return to IDLE SHALL be accepted on the following cycle; no extra idle time SHALL be required between frames beyond the stop bit's second half.
REQ-020 i_rx changes during the counting portions of any bit (outside the sample cycle) SHALL have no effect.

Reset
REQ-021 While i_rst is high: state=IDLE, counters=0, shift register=0, o_data=8'h00, o_valid=0, o_frame_err=0, o_busy=0, synchronizer=1.
REQ-022 Reset asserted mid-frame SHALL abort the frame immediately with no pulse on o_valid or o_frame_err; reception SHALL resume with the first start edge after deassertion.

Verification (bench CLK_COUNT=16; a driver model sends 16-cycle bits)
REQ-023 Send 0x55, then 0xA3 back-to-back with one stop bit -> two o_valid pulses, o_data=0x55 then 0xA3, o_frame_err never high, o_busy low between frames for at most 9 cycles.
REQ-024 Drive i_rx low for 4 cycles, then high -> state returns to IDLE, o_busy high at most 12 cycles, no o_valid or o_frame_err pulse.
REQ-025 Send 0x3C with the stop bit low, then line high -> one o_frame_err pulse, o_data holds its previous value, then a following 0x81 is received correctly.
REQ-026 Hold i_rx low for 40 bit times -> exactly one o_frame_err, o_busy stays high until the line returns high, no o_valid pulse.
REQ-027 Assert i_rst during data bit 4 of 0xF0 -> all outputs return to reset values immediately, no pulses; the next frame, 0x0F, is received with o_data=0x0F.
REQ-028 Send 0x00 and 0xFF -> o_valid pulse at the REQ-018 latency (+/-1), o_data correct for each.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver, 8N1, LSB first, oversampled by a cycle counter.
// The line is synchronised, the start bit is confirmed at its midpoint,
// and every following bit is sampled one bit period later (its midpoint).
module uart_rx #(
  parameter int CLK_COUNT = 434
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_busy
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START_BIT = 3'd1,
    DATA_BIT  = 3'd2,
    STOP_BIT  = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  // Terminal counts: half a bit to reach the start-bit midpoint, a full bit afterwards.
  localparam logic [12:0] HALF_TC = 13'(CLK_COUNT / 2 - 1);
  localparam logic [12:0] FULL_TC = 13'(CLK_COUNT - 1);

  logic        rx_meta_q;
  logic        rx_s_q;
  state_t      state_q;
  logic [12:0] cnt_q;
  logic [2:0]  idx_q;
  logic [7:0]  shift_q;
  logic [7:0]  data_q;
  logic        valid_q;
  logic        frame_err_q;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= i_rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Receive FSM with registered data and one-cycle status pulses.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          idx_q <= '0;
          if (!rx_s_q) begin
            state_q <= START_BIT;
          end
        end
        START_BIT: begin
          if (cnt_q == HALF_TC) begin
            cnt_q   <= '0;
            // A line that is high again at the midpoint was only a glitch.
            state_q <= rx_s_q ? IDLE : DATA_BIT;
          end else begin
            cnt_q <= cnt_q + 13'd1;
          end
        end
        DATA_BIT: begin
          if (cnt_q == FULL_TC) begin
            cnt_q          <= '0;
            shift_q[idx_q] <= rx_s_q;
            idx_q          <= idx_q + 3'd1;
            if (idx_q == 3'd7) begin
              state_q <= STOP_BIT;
            end
          end else begin
            cnt_q <= cnt_q + 13'd1;
          end
        end
        STOP_BIT: begin
          if (cnt_q == FULL_TC) begin
            cnt_q <= '0;
            if (rx_s_q) begin
              data_q  <= shift_q;
              valid_q <= 1'b1;
              state_q <= IDLE;
            end else begin
              // Bad stop bit: report once, then wait out a possible break.
              frame_err_q <= 1'b1;
              state_q     <= WAIT_HIGH;
            end
          end else begin
            cnt_q <= cnt_q + 13'd1;
          end
        end
        WAIT_HIGH: begin
          cnt_q <= '0;
          idx_q <= '0;
          if (rx_s_q) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          idx_q   <= '0;
        end
      endcase
    end
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_frame_err = frame_err_q;
  assign o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with a scoreboard of expected receive events.
module tb_uart_rx;

  localparam int BIT_CYC = 16;
  localparam int LAT_MIN = 2 + 1 + BIT_CYC / 2 + 9 * BIT_CYC - 1;
  localparam int LAT_MAX = 2 + 1 + BIT_CYC / 2 + 9 * BIT_CYC + 1;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_frame_err;
  logic       o_busy;

  typedef struct {
    logic       err;
    logic [7:0] data;
    int         start;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;
  int   lat;
  logic prev_pulse = 1'b0;
  logic prev_busy  = 1'b0;
  int   busy_run   = 0;
  int   idle_run   = 0;
  int   last_busy_run = 0;
  logic gap_en     = 1'b0;

  uart_rx #(.CLK_COUNT(BIT_CYC)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_rx       (rx),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .o_frame_err(o_frame_err),
    .o_busy     (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Send one frame; caller is positioned just after a rising edge.
  task automatic send(input logic [7:0] b, input logic stop, input logic exp_err,
                      input logic [7:0] exp_data);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = fr[i];
      if (i == 0) sb.push_back('{exp_err, exp_data, cyc});
      repeat (BIT_CYC) @(posedge clk);
      #1;
    end
  endtask

  // Monitor: pops the scoreboard on every pulse and tracks busy run lengths.
  always @(negedge clk) begin
    if (rst) begin
      prev_pulse = 1'b0;
      prev_busy  = 1'b0;
      busy_run   = 0;
      idle_run   = 0;
    end else begin
      if (o_valid || o_frame_err) begin
        chk("pulse_exclusive", {31'd0, o_valid & o_frame_err}, 32'd0);
        chk("pulse_back2back", {31'd0, prev_pulse}, 32'd0);
        if (sb.size() == 0) begin
          compared++;
          mismatched++;
          $error("FAIL unexpected_pulse: observed valid=%0b ferr=%0b expected no pulse",
                 o_valid, o_frame_err);
        end else begin
          e   = sb.pop_front();
          lat = cyc - e.start;
          $display("rx event: data=%02h ferr=%0b latency=%0d", o_data, o_frame_err, lat);
          chk("pulse_kind_ferr", {31'd0, o_frame_err}, {31'd0, e.err});
          chk("rx_data", {24'd0, o_data}, {24'd0, e.data});
          compared++;
          assert (lat >= LAT_MIN && lat <= LAT_MAX) else begin
            mismatched++;
            $error("FAIL latency: observed %0d expected %0d..%0d", lat, LAT_MIN, LAT_MAX);
          end
        end
        prev_pulse = 1'b1;
      end else begin
        prev_pulse = 1'b0;
      end
      if (o_busy) begin
        if (!prev_busy && gap_en) begin
          compared++;
          assert (idle_run >= 1 && idle_run <= 9) else begin
            mismatched++;
            $error("FAIL interframe_gap: observed %0d expected 1..9", idle_run);
          end
          gap_en = 1'b0;
        end
        busy_run++;
        idle_run = 0;
      end else begin
        if (prev_busy) last_busy_run = busy_run;
        busy_run = 0;
        idle_run++;
      end
      prev_busy = o_busy;
    end
  end

  initial begin
    #(20000 * 10);
    $display("FAIL timeout: observed no finish expected finish within 20000 cycles");
    $fatal(1, "timeout");
  end

  initial begin
    int waited;
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_data", {24'd0, o_data}, 32'h00);
    chk("reset_valid", {31'd0, o_valid}, 32'd0);
    chk("reset_ferr", {31'd0, o_frame_err}, 32'd0);
    chk("reset_busy", {31'd0, o_busy}, 32'd0);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    // Back-to-back frames with a single stop bit.
    send(8'h55, 1'b1, 1'b0, 8'h55);
    gap_en = 1'b1;
    send(8'hA3, 1'b1, 1'b0, 8'hA3);
    repeat (40) @(posedge clk);
    #1;
    chk("gap_measured", {31'd0, gap_en}, 32'd0);
    chk("data_after_a3", {24'd0, o_data}, 32'hA3);

    // Short low glitch is rejected at the start-bit midpoint.
    last_busy_run = 0;
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    compared++;
    assert (last_busy_run >= 1 && last_busy_run <= 12) else begin
      mismatched++;
      $error("FAIL glitch_busy: observed %0d expected 1..12", last_busy_run);
    end
    chk("glitch_idle", {31'd0, o_busy}, 32'd0);

    // Framing error keeps the previous byte, then a good byte follows.
    send(8'h3C, 1'b0, 1'b1, 8'hA3);
    rx = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("ferr_data_held", {24'd0, o_data}, 32'hA3);
    send(8'h81, 1'b1, 1'b0, 8'h81);
    repeat (20) @(posedge clk);
    #1;

    // Break: line low for 40 bit times gives exactly one framing error.
    sb.push_back('{1'b1, 8'h81, cyc});
    rx = 1'b0;
    repeat (20 * BIT_CYC) @(posedge clk);
    #1;
    chk("break_busy_mid", {31'd0, o_busy}, 32'd1);
    repeat (20 * BIT_CYC) @(posedge clk);
    #1;
    chk("break_busy_end", {31'd0, o_busy}, 32'd1);
    rx = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("break_released", {31'd0, o_busy}, 32'd0);
    chk("break_data_held", {24'd0, o_data}, 32'h81);

    // Reset in the middle of data bit 4 of 0xF0 (start and bits 0..3 are low).
    rx = 1'b0;
    repeat (5 * BIT_CYC + BIT_CYC / 2) @(posedge clk);
    #1;
    chk("pre_reset_busy", {31'd0, o_busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("midreset_data", {24'd0, o_data}, 32'h00);
    chk("midreset_busy", {31'd0, o_busy}, 32'd0);
    chk("midreset_valid", {31'd0, o_valid}, 32'd0);
    chk("midreset_ferr", {31'd0, o_frame_err}, 32'd0);
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    send(8'h0F, 1'b1, 1'b0, 8'h0F);
    send(8'h00, 1'b1, 1'b0, 8'h00);
    send(8'hFF, 1'b1, 1'b0, 8'hFF);

    waited = 0;
    while (sb.size() != 0 && waited < 400) begin
      @(posedge clk);
      waited++;
    end
    #1;
    chk("scoreboard_drained", sb.size(), 32'd0);
    chk("final_data", {24'd0, o_data}, 32'hFF);
    chk("final_idle", {31'd0, o_busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
